// File: rtl/acc_dp_pkg.sv
// Shared encodings for the accumulator datapath: ALU ops, ACC source select,
// multiplier FSM states and flag bit positions.
package acc_dp_pkg;

  typedef enum logic [2:0] {
    ALU_SUB = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SELA_MEM  = 2'd0,
    SELA_IMM  = 2'd1,
    SELA_ALU  = 2'd2,
    SELA_HOLD = 2'd3
  } sel_a_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/acc_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle (LSB first),
// keeping only the low DATA_W bits of the product.
module acc_mul_seq
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              finish_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, prod_q;
  logic              busy_q, done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MUL_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: if (start_i) state_d = MUL_RUN;
      MUL_RUN:  if (cnt_q == CNT_W'(DATA_W - 1)) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_comb begin
    finish_o  = (state_q == MUL_DONE);
    product_o = prod_q;
    busy_o    = busy_q;
    done_o    = done_q;
  end

  // busy covers RUN and DONE; done rises as the top writes the product into ACC
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != MUL_IDLE);
      done_q <= (state_q == MUL_DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (state_q == MUL_IDLE && start_i) begin
      cnt_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      prod_q   <= '0;
    end else if (state_q == MUL_RUN) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/acc_datapath_mc.sv
// Accumulator datapath: ACC register, ALU with Z/N/C/V flags and a
// multi-cycle multiplier that stalls the control unit through busy.
module acc_datapath_mc
  import acc_dp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPND_W = 11,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [OPND_W-1:0] operand_i,
  input  logic [1:0]        sel_a_i,
  input  logic              sel_b_i,
  input  logic [2:0]        alu_op_i,
  input  logic              wr_acc_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [3:0]        flags_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]        acc_q, acc_d;
  logic [3:0]               flags_q, flags_d;
  logic [DATA_W-1:0]        immExt, bOp, aluRes, product;
  logic                     aluC, aluV;
  logic [DATA_W:0]          sumTmp, shlTmp;
  logic signed [DATA_W:0]   sraTmp;
  logic [SH_W-1:0]          shamt;
  logic                     mulStart, mulFinish, mulBusy, mulDone;

  assign immExt     = DATA_W'($signed(operand_i));
  assign bOp        = sel_b_i ? immExt : in_data_i;
  assign shamt      = bOp[SH_W-1:0];
  assign addr_o     = operand_i[ADDR_W-1:0];
  assign out_data_o = acc_q;
  assign flags_o    = flags_q;
  assign busy_o     = mulBusy;
  assign done_o     = mulDone;

  // A trigger landing on the done cycle is dropped; control re-issues it
  assign mulStart = wr_acc_i && !mulBusy && !mulDone &&
                    (sel_a_i == SELA_ALU) && (alu_op_i == ALU_MUL);

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    sumTmp = '0;
    shlTmp = {1'b0, acc_q} << shamt;
    sraTmp = $signed({acc_q, 1'b0}) >>> shamt;
    unique case (alu_op_i)
      ALU_ADD: begin
        sumTmp = {1'b0, acc_q} + {1'b0, bOp};
        aluRes = sumTmp[DATA_W-1:0];
        aluC   = sumTmp[DATA_W];
        aluV   = (acc_q[DATA_W-1] == bOp[DATA_W-1]) && (aluRes[DATA_W-1] != acc_q[DATA_W-1]);
      end
      ALU_SUB: begin
        aluRes = acc_q - bOp;
        aluC   = (acc_q >= bOp);
        aluV   = (acc_q[DATA_W-1] != bOp[DATA_W-1]) && (aluRes[DATA_W-1] != acc_q[DATA_W-1]);
      end
      ALU_AND: aluRes = acc_q & bOp;
      ALU_OR:  aluRes = acc_q | bOp;
      ALU_XOR: aluRes = acc_q ^ bOp;
      ALU_SLL: begin
        aluRes = shlTmp[DATA_W-1:0];
        aluC   = shlTmp[DATA_W];
      end
      ALU_SRA: begin
        aluRes = sraTmp[DATA_W:1];
        aluC   = sraTmp[0];
      end
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (mulFinish) begin
      acc_d           = product;
      flags_d         = '0;
      flags_d[FLAG_Z] = (product == '0);
      flags_d[FLAG_N] = product[DATA_W-1];
    end else if (wr_acc_i && !mulBusy) begin
      unique case (sel_a_i)
        SELA_MEM: acc_d = in_data_i;
        SELA_IMM: acc_d = immExt;
        SELA_ALU: begin
          if (alu_op_i != ALU_MUL) begin
            acc_d           = aluRes;
            flags_d[FLAG_Z] = (aluRes == '0);
            flags_d[FLAG_N] = aluRes[DATA_W-1];
            flags_d[FLAG_C] = aluC;
            flags_d[FLAG_V] = aluV;
          end
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  acc_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (mulStart),
    .mcand_i  (acc_q),
    .mplier_i (bOp),
    .busy_o   (mulBusy),
    .done_o   (mulDone),
    .finish_o (mulFinish),
    .product_o(product)
  );

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Directed self-checking bench for acc_datapath_mc with DATA_W=16, OPND_W=11.
module tb_acc_datapath_mc;
  import acc_dp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [10:0] operand_i = '0;
  logic [1:0]  sel_a_i = 2'd3;
  logic        sel_b_i = 1'b0;
  logic [2:0]  alu_op_i = 3'd0;
  logic        wr_acc_i = 1'b0;
  logic [15:0] in_data_i = '0;
  logic [10:0] addr_o;
  logic [15:0] out_data_o;
  logic [3:0]  flags_o;
  logic        busy_o, done_o;

  int testsRun = 0;
  int testsFailed = 0;

  acc_datapath_mc #(.DATA_W(16), .OPND_W(11), .ADDR_W(11)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .operand_i (operand_i),
    .sel_a_i   (sel_a_i),
    .sel_b_i   (sel_b_i),
    .alu_op_i  (alu_op_i),
    .wr_acc_i  (wr_acc_i),
    .in_data_i (in_data_i),
    .addr_o    (addr_o),
    .out_data_o(out_data_o),
    .flags_o   (flags_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Issues one write-strobed instruction and samples 1ns after its edge
  task automatic doOp(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                      input logic [15:0] din, input logic [10:0] opnd);
    sel_a_i = sa; sel_b_i = sb; alu_op_i = op; in_data_i = din; operand_i = opnd;
    wr_acc_i = 1'b1;
    @(posedge clk_i); #1;
    wr_acc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    testsRun++;
    if ({out_data_o, flags_o, busy_o, done_o} !== 22'd0) begin
      $display("[TB] FAIL reset_state got acc=%h flags=%b busy=%b done=%b want 0", out_data_o, flags_o, busy_o, done_o);
      testsFailed++;
    end
    @(negedge clk_i); rst_ni = 1'b1;
    operand_i = 11'h2A5; #1;
    testsRun++;
    if (addr_o !== 11'h2A5) begin
      $display("[TB] FAIL addr got %h want 2a5", addr_o);
      testsFailed++;
    end
  endtask

  task automatic test_load();
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'd5, 11'h0);
    testsRun++;
    if (out_data_o !== 16'd5 || flags_o !== 4'b0000) begin
      $display("[TB] FAIL load_mem got acc=%h flags=%b want 0005 0000", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_IMM, 1'b0, ALU_ADD, 16'd0, 11'h7F1);
    testsRun++;
    if (out_data_o !== 16'hFFF1 || addr_o !== 11'h7F1) begin
      $display("[TB] FAIL load_imm got acc=%h addr=%h want fff1 7f1", out_data_o, addr_o);
      testsFailed++;
    end
    sel_a_i = SELA_HOLD; wr_acc_i = 1'b1; in_data_i = 16'h1234;
    @(posedge clk_i); #1;
    sel_a_i = SELA_MEM; wr_acc_i = 1'b0;
    @(posedge clk_i); #1;
    testsRun++;
    if (out_data_o !== 16'hFFF1) begin
      $display("[TB] FAIL hold got acc=%h want fff1", out_data_o);
      testsFailed++;
    end
  endtask

  task automatic test_addsub();
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'h7FFF, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_ADD, 16'h0001, 11'h0);
    testsRun++;
    if (out_data_o !== 16'h8000 || flags_o !== 4'b0101) begin
      $display("[TB] FAIL add_ovf got acc=%h flags=%b want 8000 0101", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b0, ALU_SUB, 16'h8000, 11'h0);
    testsRun++;
    if (out_data_o !== 16'h0000 || flags_o !== 4'b1010) begin
      $display("[TB] FAIL sub_zero got acc=%h flags=%b want 0000 1010", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b1, ALU_SUB, 16'h0, 11'h001);
    testsRun++;
    if (out_data_o !== 16'hFFFF || flags_o !== 4'b0100) begin
      $display("[TB] FAIL sub_borrow got acc=%h flags=%b want ffff 0100", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'h0042, 11'h0);
    testsRun++;
    if (flags_o !== 4'b0100) begin
      $display("[TB] FAIL load_keeps_flags got %b want 0100", flags_o);
      testsFailed++;
    end
  endtask

  task automatic test_logic();
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'hF0F0, 11'h0);
    doOp(SELA_ALU, 1'b1, ALU_ADD, 16'h0, 11'h7FF);
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'hF0F0, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_AND, 16'h0FF0, 11'h0);
    testsRun++;
    if (out_data_o !== 16'h00F0 || flags_o !== 4'b0000) begin
      $display("[TB] FAIL and got acc=%h flags=%b want 00f0 0000", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b1, ALU_OR, 16'h0, 11'h400);
    testsRun++;
    if (out_data_o !== 16'hFCF0 || flags_o !== 4'b0100) begin
      $display("[TB] FAIL or got acc=%h flags=%b want fcf0 0100", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b0, ALU_XOR, 16'hFCF0, 11'h0);
    testsRun++;
    if (out_data_o !== 16'h0000 || flags_o !== 4'b1000) begin
      $display("[TB] FAIL xor got acc=%h flags=%b want 0000 1000", out_data_o, flags_o);
      testsFailed++;
    end
  endtask

  task automatic test_shift();
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'h8001, 11'h0);
    doOp(SELA_ALU, 1'b1, ALU_SRA, 16'h0, 11'd1);
    testsRun++;
    if (out_data_o !== 16'hC000 || flags_o !== 4'b0110) begin
      $display("[TB] FAIL sra got acc=%h flags=%b want c000 0110", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b1, ALU_SLL, 16'h0, 11'd2);
    testsRun++;
    if (out_data_o !== 16'h0000 || flags_o !== 4'b1010) begin
      $display("[TB] FAIL sll got acc=%h flags=%b want 0000 1010", out_data_o, flags_o);
      testsFailed++;
    end
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'h00A5, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_SLL, 16'h0010, 11'h0);
    testsRun++;
    if (out_data_o !== 16'h00A5 || flags_o !== 4'b0000) begin
      $display("[TB] FAIL sll_zero_amt got acc=%h flags=%b want 00a5 0000", out_data_o, flags_o);
      testsFailed++;
    end
  endtask

  task automatic test_multiply();
    int busyCycles;
    bit sawDone;
    bit heldOk;
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'd300, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_MUL, 16'd200, 11'h0);
    busyCycles = busy_o ? 1 : 0;
    sawDone = 1'b0;
    heldOk = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data_i = 16'h5555;
      operand_i = 11'h3FF;
      if (out_data_o !== 16'd300) heldOk = 1'b0;
      @(posedge clk_i); #1;
      if (done_o) begin
        sawDone = 1'b1;
        break;
      end
      if (busy_o) busyCycles++;
    end
    testsRun++;
    if (!sawDone) begin
      $display("[TB] FAIL mul_done_timeout got done=0 want pulse within 40 cycles");
      testsFailed++;
    end
    testsRun++;
    if (busyCycles != 17 || !heldOk) begin
      $display("[TB] FAIL mul_busy got busy_cycles=%0d held=%0d want 17 1", busyCycles, heldOk);
      testsFailed++;
    end
    testsRun++;
    if (out_data_o !== 16'hEA60 || flags_o !== 4'b0100 || busy_o !== 1'b0) begin
      $display("[TB] FAIL mul_result got acc=%h flags=%b busy=%b want ea60 0100 0", out_data_o, flags_o, busy_o);
      testsFailed++;
    end
    @(posedge clk_i); #1;
    testsRun++;
    if (done_o !== 1'b0 || out_data_o !== 16'hEA60) begin
      $display("[TB] FAIL mul_done_pulse got done=%b acc=%h want 0 ea60", done_o, out_data_o);
      testsFailed++;
    end
  endtask

  task automatic test_back_to_back();
    bit sawDone;
    bit heldOk;
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'd3, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_MUL, 16'd5, 11'h0);
    sel_a_i = SELA_MEM; wr_acc_i = 1'b1; in_data_i = 16'd9;
    sawDone = 1'b0;
    heldOk = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        sawDone = 1'b1;
        break;
      end
      if (out_data_o !== 16'd3) heldOk = 1'b0;
    end
    testsRun++;
    if (!sawDone || !heldOk || out_data_o !== 16'h000F) begin
      $display("[TB] FAIL stall got done=%b held=%b acc=%h want 1 1 000f", sawDone, heldOk, out_data_o);
      testsFailed++;
    end
    sel_a_i = SELA_ALU; alu_op_i = ALU_MUL; in_data_i = 16'd5; wr_acc_i = 1'b1;
    @(posedge clk_i); #1;
    wr_acc_i = 1'b0;
    testsRun++;
    if (busy_o !== 1'b0 || out_data_o !== 16'h000F) begin
      $display("[TB] FAIL trigger_on_done got busy=%b acc=%h want 0 000f", busy_o, out_data_o);
      testsFailed++;
    end
    @(posedge clk_i); #1;
    testsRun++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("[TB] FAIL no_second_mul got busy=%b done=%b want 0 0", busy_o, done_o);
      testsFailed++;
    end
  endtask

  task automatic test_reset_mid_mul();
    bit sawDone;
    doOp(SELA_MEM, 1'b0, ALU_ADD, 16'd300, 11'h0);
    doOp(SELA_ALU, 1'b0, ALU_MUL, 16'd200, 11'h0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk_i); #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    testsRun++;
    if (out_data_o !== 16'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || flags_o !== 4'b0000) begin
      $display("[TB] FAIL reset_mid_mul got acc=%h busy=%b done=%b flags=%b want 0 0 0 0", out_data_o, busy_o, done_o, flags_o);
      testsFailed++;
    end
    @(negedge clk_i); rst_ni = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone || out_data_o !== 16'd0) begin
      $display("[TB] FAIL abort_no_done got activity=%b acc=%h want 0 0000", sawDone, out_data_o);
      testsFailed++;
    end
    doOp(SELA_ALU, 1'b1, ALU_ADD, 16'h0, 11'd3);
    testsRun++;
    if (out_data_o !== 16'd3 || flags_o !== 4'b0000) begin
      $display("[TB] FAIL add_after_reset got acc=%h flags=%b want 0003 0000", out_data_o, flags_o);
      testsFailed++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_addsub();
    test_logic();
    test_shift();
    test_multiply();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
